pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides. The WIDTH-bit operation is split into SEG_WIDTH-bit lookahead segments, one segment per pipeline stage, with the carry forwarded stage to stage. It sustains one operation per cycle under backpressure. It replaces fixed-width registered adders in datapaths that need wider operands, higher clock rates or subtraction.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 8, bits resolved per pipeline stage. STAGES = WIDTH/SEG_WIDTH, and STAGES must be at least 1.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH+1  result; bit WIDTH is carry-out (add) or borrow (sub).
- out_ovf  out  1  two's-complement signed overflow of the WIDTH-bit result.

## Operation
- Transfer occurs on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
- Subtraction is computed as A + ~B + 1: B is inverted and the stage-0 carry-in is in_sub.
- Stage k (0..STAGES−1) computes result bits [k·SEG_WIDTH +: SEG_WIDTH] from:
  - the delayed operand slices, and
  - the carry registered by stage k−1.
- Upper operand slices and in_sub travel with the operation; lower result slices are carried forward. Every stage holds a valid bit.
- Carry-out c = carry out of the top segment.
- out_sum[WIDTH] = c for add; = ~c (borrow, set when A < B unsigned) for sub.
- out_ovf = carry into the MSB XOR carry out of the MSB.
- Global stall: en = ~out_valid | out_ready.
  - When en = 0, every stage holds its data and valid bit.
  - When en = 1, all stages advance and bubbles collapse only by advancing.
- in_ready = en, and is combinational from out_ready and out_valid.
- Operations leave in acceptance order; none are lost or duplicated.
- Reset clears all valid bits, data registers and the carry chain. All outputs read 0 the cycle after reset is sampled high: out_valid=0, out_sum=0, out_ovf=0.
  - in_ready reads 1 after reset.
  - Reset during operation discards all in-flight operations.
  - Reset has priority over any simultaneous transfer.

## Timing
- Latency is STAGES cycles from the accept edge to out_valid high, assuming no stall (4 for the defaults).
- Throughput is one operation per cycle when out_ready is held at 1.
- The output register is the last stage. out_sum and out_ovf are stable while out_valid && !out_ready.
- A stall cycle adds exactly one cycle of latency to every in-flight operation.
- in_ready falls in the same cycle that out_valid=1 and out_ready=0, so no operand is accepted into a full pipe.
- When out_ready=1, a simultaneous accept and emit is legal.
- STAGES=1 degenerates to a single registered CLA with the same handshake.
- The critical path is one SEG_WIDTH lookahead segment plus the carry-in mux.

## Structure
- A shared package holds:
  - the mode constants MODE_ADD=0 and MODE_SUB=1;
  - the function stages(WIDTH, SEG_WIDTH);
  - the elaboration check that WIDTH % SEG_WIDTH == 0.
- Sub-module cla_segment (combinational, parameter N): generate/propagate lookahead. Inputs a[N], b[N], cin. Outputs s[N], cout, and the carry into the MSB (c_msb) for overflow detection.
- The top level is a generate loop of STAGES stage registers, each instantiating cla_segment, plus the shared stall enable.

## Test plan
- Add 0xFFFFFFFF + 0x00000001 with out_ready=1. Required response: out_sum=0x1_00000000 and out_ovf=0, exactly 4 cycles after accept.
- Add 0x7FFFFFFF + 0x00000001. Required response: out_sum=0x0_80000000, out_ovf=1.
- Subtract 5 − 7. Required response: out_sum=0x1_FFFFFFFE (borrow=1), out_ovf=0.
- Subtract 0x80000000 − 1. Required response: out_sum=0x0_7FFFFFFF, out_ovf=1.
- Stream 16 random back-to-back operations while out_ready follows the pattern 1,0,0,1,… Required response:
  - all 16 results match the reference model in order;
  - in_ready = 0 exactly on the cycles with out_valid=1 and out_ready=0;
  - outputs do not change while stalled.
- Assert reset for one cycle with 3 operations in flight. Required response:
  - the next cycle shows out_valid=0, out_sum=0, in_ready=1;
  - the next accepted operation emerges after 4 cycles;
  - no stale result appears.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// operation modes, stage-count helper and the width legality check.
package pipelined_cla_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int stages(input int width, input int seg_width);
        return width / seg_width;
    endfunction

    function automatic bit width_ok(input int width, input int seg_width);
        return (seg_width > 0) && (width >= seg_width) && ((width % seg_width) == 0);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_segment.sv
// Combinational N-bit carry-lookahead segment; also exposes the carry into
// the MSB so the caller can derive signed overflow.
module cla_segment
    import pipelined_cla_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [N-1:0] g_s;
    logic [N-1:0] p_s;
    logic [N:0]   c_s;
    logic         prop_s;
    logic         term_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Each carry is a flat sum of generate terms gated by propagate prefixes.
    always_comb begin
        c_s    = '0;
        prop_s = 1'b1;
        term_s = 1'b0;
        c_s[0] = cin;
        for (int i = 0; i < N; i++) begin
            prop_s = 1'b1;
            term_s = 1'b0;
            for (int j = i; j >= 0; j--) begin
                term_s = term_s | (g_s[j] & prop_s);
                prop_s = prop_s & p_s[j];
            end
            c_s[i+1] = term_s | (prop_s & cin);
        end
    end

    assign s     = p_s ^ c_s[N-1:0];
    assign cout  = c_s[N];
    assign c_msb = c_s[N-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one SEG_WIDTH segment per stage, carry
// forwarded between stages, one global stall enable shared by all stages.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);

    localparam int STAGES = stages(WIDTH, SEG_WIDTH);

    if (!width_ok(WIDTH, SEG_WIDTH)) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of SEG_WIDTH");
    end

    logic                 en_s;
    logic                 valid_q [STAGES];
    logic                 valid_d [STAGES];
    logic [WIDTH-1:0]     a_q     [STAGES];
    logic [WIDTH-1:0]     a_d     [STAGES];
    logic [WIDTH-1:0]     b_q     [STAGES];
    logic [WIDTH-1:0]     b_d     [STAGES];
    logic [WIDTH-1:0]     res_q   [STAGES];
    logic [WIDTH-1:0]     res_d   [STAGES];
    logic                 carry_q [STAGES];
    logic                 carry_d [STAGES];
    logic                 sub_q   [STAGES];
    logic                 sub_d   [STAGES];
    logic                 top_q;
    logic                 top_d;
    logic                 ovf_q;
    logic                 ovf_d;

    logic                 prev_valid_s [STAGES];
    logic [WIDTH-1:0]     prev_a_s     [STAGES];
    logic [WIDTH-1:0]     prev_b_s     [STAGES];
    logic [WIDTH-1:0]     prev_res_s   [STAGES];
    logic                 prev_cin_s   [STAGES];
    logic                 prev_sub_s   [STAGES];
    logic [SEG_WIDTH-1:0] seg_sum_s    [STAGES];
    logic                 seg_cout_s   [STAGES];
    logic                 seg_cmsb_s   [STAGES];

    assign en_s = ~valid_q[STAGES-1] | out_ready;

    // Stage k reads what stage k-1 registered; stage 0 reads the ports, with
    // B inverted and the carry-in set for subtraction.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign prev_valid_s[k] = in_valid;
            assign prev_a_s[k]     = in_a;
            assign prev_b_s[k]     = (in_sub == MODE_SUB) ? ~in_b : in_b;
            assign prev_res_s[k]   = '0;
            assign prev_cin_s[k]   = in_sub;
            assign prev_sub_s[k]   = in_sub;
        end else begin : g_next
            assign prev_valid_s[k] = valid_q[k-1];
            assign prev_a_s[k]     = a_q[k-1];
            assign prev_b_s[k]     = b_q[k-1];
            assign prev_res_s[k]   = res_q[k-1];
            assign prev_cin_s[k]   = carry_q[k-1];
            assign prev_sub_s[k]   = sub_q[k-1];
        end

        cla_segment #(
            .N(SEG_WIDTH)
        ) u_seg (
            .a    (prev_a_s[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .b    (prev_b_s[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .cin  (prev_cin_s[k]),
            .s    (seg_sum_s[k]),
            .cout (seg_cout_s[k]),
            .c_msb(seg_cmsb_s[k])
        );
    end

    // Next-state for every stage; data only loads under a valid, so bubbles keep outputs quiet.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        top_d   = top_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            if (en_s) begin
                valid_d[k] = prev_valid_s[k];
            end else begin
                valid_d[k] = valid_q[k];
            end
            if (en_s && prev_valid_s[k]) begin
                a_d[k]     = prev_a_s[k];
                b_d[k]     = prev_b_s[k];
                res_d[k]   = prev_res_s[k];
                res_d[k][k*SEG_WIDTH +: SEG_WIDTH] = seg_sum_s[k];
                carry_d[k] = seg_cout_s[k];
                sub_d[k]   = prev_sub_s[k];
            end else begin
                a_d[k]     = a_q[k];
                b_d[k]     = b_q[k];
                res_d[k]   = res_q[k];
                carry_d[k] = carry_q[k];
                sub_d[k]   = sub_q[k];
            end
        end
        if (en_s && prev_valid_s[STAGES-1]) begin
            ovf_d = seg_cmsb_s[STAGES-1] ^ seg_cout_s[STAGES-1];
            case (prev_sub_s[STAGES-1])
                MODE_ADD: top_d = seg_cout_s[STAGES-1];
                MODE_SUB: top_d = ~seg_cout_s[STAGES-1];
                default:  top_d = seg_cout_s[STAGES-1];
            endcase
        end else begin
            ovf_d = ovf_q;
            top_d = top_q;
        end
    end

    // Pipeline registers with synchronous reset taking priority over any transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                res_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                sub_q[k]   <= 1'b0;
            end
            top_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = en_s;
    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = {top_q, res_q[STAGES-1]};
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder against an arithmetic reference model.
module tb_pipelined_cla_adder;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;
    logic         out_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    pipelined_cla_adder #(
        .WIDTH    (W),
        .SEG_WIDTH(8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf)
    );

    // Reference: {ovf, carry/borrow, W-bit result} from plain arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        logic [W:0] r;
        logic       ovf;
        if (sub) begin
            r[W-1:0] = a - b;
            r[W]     = (a < b);
            ovf      = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r   = {1'b0, a} + {1'b0, b};
            ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {ovf, r};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_sum !== 33'h0) $display("FAIL reset_out_sum: got %h want 0", out_sum);
        else pass_cnt++;
        total_cnt++;
        if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b want 0", out_ovf);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                              input logic [W:0] exp_sum, input logic exp_ovf, input string name);
        int n;
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n != 4) $display("FAIL %s_latency: got %0d cycles want 4", name, n);
        else pass_cnt++;
        total_cnt++;
        if (out_sum !== exp_sum) $display("FAIL %s_sum: got %h want %h", name, out_sum, exp_sum);
        else pass_cnt++;
        total_cnt++;
        if (out_ovf !== exp_ovf) $display("FAIL %s_ovf: got %b want %b", name, out_ovf, exp_ovf);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_directed();
        run_single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1'b0, "add_carry");
        run_single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1, "add_ovf");
        run_single(32'h0000_0005, 32'h0000_0007, 1'b1, 33'h1_FFFF_FFFE, 1'b0, "sub_borrow");
        run_single(32'h8000_0000, 32'h0000_0001, 1'b1, 33'h0_7FFF_FFFF, 1'b1, "sub_ovf");
    endtask

    task automatic test_random_single();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W+1:0] e;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            e = model(a, b, s);
            run_single(a, b, s, e[W:0], e[W+1], "rand_single");
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] exp_q[$];
        logic [W+1:0] e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         exp_ready;
        logic         stalled_prev;
        logic [W:0]   held_sum;
        logic         held_ovf;
        int sent;
        int got;
        int cyc;
        sent = 0; got = 0; cyc = 0; stalled_prev = 1'b0; held_sum = '0; held_ovf = 1'b0;
        a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
        while (got < 16 && cyc < 400) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            in_valid  = (sent < 16);
            in_a = a; in_b = b; in_sub = s;
            #1;
            exp_ready = !(out_valid && !out_ready);
            total_cnt++;
            if (in_ready !== exp_ready)
                $display("FAIL b2b_in_ready: cycle %0d got %b want %b", cyc, in_ready, exp_ready);
            else pass_cnt++;
            if (stalled_prev) begin
                total_cnt++;
                if (out_valid !== 1'b1 || out_sum !== held_sum || out_ovf !== held_ovf)
                    $display("FAIL b2b_stall_hold: cycle %0d got v=%b %h/%b want v=1 %h/%b",
                             cyc, out_valid, out_sum, out_ovf, held_sum, held_ovf);
                else pass_cnt++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra: got unexpected result %h want none", out_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_ovf, out_sum} !== e)
                        $display("FAIL b2b_result: result %0d got %h/%b want %h/%b",
                                 got, out_sum, out_ovf, e[W:0], e[W+1]);
                    else pass_cnt++;
                end
                got++;
            end
            if (in_valid && exp_ready) begin
                exp_q.push_back(model(a, b, s));
                sent++;
                a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            end
            stalled_prev = (out_valid === 1'b1) && !out_ready;
            held_sum = out_sum;
            held_ovf = out_ovf;
            tick();
            cyc++;
        end
        total_cnt++;
        if (got != 16) $display("FAIL b2b_count: got %0d results want 16", got);
        else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset_flush();
        logic [W+1:0] e;
        logic [W+1:0] seen_v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        int n;
        int seen;
        int first_n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            tick();
        end
        in_a = $urandom; in_b = $urandom; in_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_sum !== 33'h0) $display("FAIL flush_out_sum: got %h want 0", out_sum);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
        e = model(a, b, s);
        in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1; seen = 0; first_n = 0; seen_v = '0;
        repeat (12) begin
            if (out_valid === 1'b1) begin
                seen++;
                if (seen == 1) begin
                    first_n = n;
                    seen_v  = {out_ovf, out_sum};
                end
            end
            tick();
            n++;
        end
        total_cnt++;
        if (seen != 1) $display("FAIL flush_result_count: got %0d results want 1", seen);
        else pass_cnt++;
        total_cnt++;
        if (first_n != 4) $display("FAIL flush_latency: got %0d cycles want 4", first_n);
        else pass_cnt++;
        total_cnt++;
        if (seen_v !== e) $display("FAIL flush_result: got %h want %h", seen_v, e);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random_single();
        test_back_to_back();
        test_reset_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
